// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the RAM/decode side.
// The slave modport is the arbiter's view; master is the requesters' and RAM's view.
interface ram_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_done;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_done;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read, busy,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read, busy,
    output mem_rdata
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-port round-robin arbiter serialising accesses onto one data-RAM bus.
// Define ARB_FIXED_PRIO_EN to make port 0 always win a tie (no round-robin state).
module ram_bus_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  ram_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic [2:0]    r_cnt;

  logic w_any_req;
  logic w_win;
  logic w_lat_hit;
  logic w_gnt;
  logic w_done;
  logic w_write;
  logic w_read;

  assign w_any_req = bus.m0_req | bus.m1_req;
  // r_cnt holds the index of the current WAIT cycle, ISSUE being cycle 0
  assign w_lat_hit = (r_cnt == 3'(READ_LAT));

`ifdef ARB_FIXED_PRIO_EN
  assign w_win = ~bus.m0_req;
`else
  logic r_rr_last;

  assign w_win = (bus.m0_req & bus.m1_req) ? ~r_rr_last : bus.m1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_rr_last <= w_win;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_done       = 1'b0;
    w_write      = 1'b0;
    w_read       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) w_state_next = ISSUE;
      end
      ISSUE: begin
        w_gnt        = 1'b1;
        w_write      = r_we;
        w_read       = ~r_we;
        w_state_next = r_we ? DONE : WAIT;
      end
      WAIT: begin
        if (w_lat_hit) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_win   <= w_win;
            r_we    <= w_win ? bus.m1_we    : bus.m0_we;
            r_addr  <= w_win ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= w_win ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        ISSUE: r_cnt <= 3'd1;
        WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_lat_hit) begin
            if (r_win) r_rdata1 <= bus.mem_rdata;
            else       r_rdata0 <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Address/data hold their captured value outside ISSUE; only the strobes qualify them
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_write = w_write;
  assign bus.mem_read  = w_read;
  assign bus.busy      = (r_state != IDLE);
  assign bus.m0_gnt    = w_gnt & ~r_win;
  assign bus.m1_gnt    = w_gnt & r_win;
  assign bus.m0_done   = w_done & ~r_win;
  assign bus.m1_done   = w_done & r_win;
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomised bench for ram_bus_arbiter: requester and RAM models drive the bus, and a
// transaction-timeline reference model predicts every output on every cycle.
module tb_ram_bus_arbiter;
  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int READ_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_bus_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // requester models
  txn_t dq0[$];
  txn_t dq1[$];
  logic req_r[2];
  txn_t fld[2];
  bit   outst[2];
  bit   done_seen[2];
  bit   gnt_seen[2];
  int   new_pct, keep_pct, drop_pct, rst_rand;
  bit   rst_next, rst_prev;

  // RAM model seen by the DUT
  logic [DW-1:0] ram [logic [AW-1:0]];
  bit            rd_v[8];
  logic [AW-1:0] rd_a[8];

  // reference model
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            t_act;
  logic          t_win;
  txn_t          t_f;
  int            t_gnt, t_done, m_next_idle;
  logic          m_last;
  logic [DW-1:0] exp_rd[2];
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_mwdata;

  int n_pass, n_chk, cyc;
  bit chk_en;

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    logic [DW-1:0] h;
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] ram_rd(logic [AW-1:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(1));
    t.addr  = 16'h8000 | 16'($urandom_range(15));
    t.wdata = 16'($urandom);
    return t;
  endfunction

  function automatic int q_size(int p);
    return (p == 0) ? dq0.size() : dq1.size();
  endfunction

  function automatic txn_t take(int p);
    if (p == 0 && dq0.size() > 0) return dq0.pop_front();
    if (p == 1 && dq1.size() > 0) return dq1.pop_front();
    return rand_txn();
  endfunction

  function automatic txn_t mk(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    t_act       = 1'b0;
    m_last      = 1'b1;
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    exp_maddr   = '0;
    exp_mwdata  = '0;
    m_next_idle = cyc + 1;
  endtask

  task automatic tick();
    int  idx;
    bit  iss, dn, bz;
    @(posedge clk);
    #1;
    cyc++;
    idx = cyc % 8;
    if (rd_v[idx]) begin
      bus.mem_rdata = ram_rd(rd_a[idx]);
      rd_v[idx] = 1'b0;
    end else begin
      bus.mem_rdata = 16'($urandom);
    end

    for (int p = 0; p < 2; p++) begin
      if (rst_prev) begin
        req_r[p] = 1'b0;
        outst[p] = 1'b0;
      end else if (done_seen[p]) begin
        outst[p] = 1'b0;
        if (q_size(p) > 0 || $urandom_range(99) < keep_pct) begin
          fld[p] = take(p); req_r[p] = 1'b1; outst[p] = 1'b1;
        end else begin
          req_r[p] = 1'b0;
        end
      end else if (gnt_seen[p] && $urandom_range(99) < drop_pct) begin
        req_r[p] = 1'b0;
        fld[p]   = rand_txn();
      end else if (!outst[p] && (q_size(p) > 0 || $urandom_range(99) < new_pct)) begin
        fld[p] = take(p); req_r[p] = 1'b1; outst[p] = 1'b1;
      end
    end

    rst           = rst_next | (rst_rand > 0 && $urandom_range(rst_rand - 1) == 0);
    bus.m0_req    = req_r[0];
    bus.m0_we     = fld[0].we;
    bus.m0_addr   = fld[0].addr;
    bus.m0_wdata  = fld[0].wdata;
    bus.m1_req    = req_r[1];
    bus.m1_we     = fld[1].we;
    bus.m1_addr   = fld[1].addr;
    bus.m1_wdata  = fld[1].wdata;

    // reference: one transaction at a time, timeline fixed when IDLE samples the requests
    if (t_act && cyc > t_done) t_act = 1'b0;
    if (!t_act && cyc >= m_next_idle && !rst && (req_r[0] || req_r[1])) begin
      if (req_r[0] && req_r[1]) begin
`ifdef ARB_FIXED_PRIO_EN
        t_win = 1'b0;
`else
        t_win = ~m_last;
`endif
      end else begin
        t_win = req_r[1];
      end
      m_last      = t_win;
      t_f         = fld[t_win];
      t_act       = 1'b1;
      t_gnt       = cyc + 1;
      t_done      = t_f.we ? cyc + 2 : cyc + 2 + READ_LAT;
      m_next_idle = t_done + 1;
    end
    if (t_act && cyc == t_gnt) begin
      exp_maddr  = t_f.addr;
      exp_mwdata = t_f.wdata;
      if (t_f.we) ref_mem[t_f.addr] = t_f.wdata;
    end
    if (t_act && cyc == t_done && !t_f.we) exp_rd[t_win] = ref_rd(t_f.addr);

    iss = t_act && cyc == t_gnt;
    dn  = t_act && cyc == t_done;
    bz  = t_act && cyc >= t_gnt && cyc <= t_done;

    @(negedge clk);
    if (chk_en) begin
      chk("m0_gnt",    32'(bus.m0_gnt),    32'(iss && t_win == 1'b0));
      chk("m1_gnt",    32'(bus.m1_gnt),    32'(iss && t_win == 1'b1));
      chk("m0_done",   32'(bus.m0_done),   32'(dn && t_win == 1'b0));
      chk("m1_done",   32'(bus.m1_done),   32'(dn && t_win == 1'b1));
      chk("mem_write", 32'(bus.mem_write), 32'(iss && t_f.we));
      chk("mem_read",  32'(bus.mem_read),  32'(iss && !t_f.we));
      chk("busy",      32'(bus.busy),      32'(bz));
      chk("mem_addr",  32'(bus.mem_addr),  32'(exp_maddr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_mwdata));
      chk("m0_rdata",  32'(bus.m0_rdata),  32'(exp_rd[0]));
      chk("m1_rdata",  32'(bus.m1_rdata),  32'(exp_rd[1]));
      if (dn)
        $display("txn cyc=%0d port=%0d %s addr=%h data=%h", cyc, t_win,
                 t_f.we ? "WR" : "RD", t_f.addr, t_f.we ? t_f.wdata : exp_rd[t_win]);
    end

    done_seen[0] = bus.m0_done;
    done_seen[1] = bus.m1_done;
    gnt_seen[0]  = bus.m0_gnt;
    gnt_seen[1]  = bus.m1_gnt;
    if (bus.mem_write === 1'b1) ram[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_read === 1'b1) begin
      rd_v[(cyc + READ_LAT) % 8] = 1'b1;
      rd_a[(cyc + READ_LAT) % 8] = bus.mem_addr;
    end
    if (rst) model_reset();
    rst_prev = rst;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_pass = 0; n_chk = 0; cyc = 0; chk_en = 1'b0;
    new_pct = 0; keep_pct = 0; drop_pct = 0; rst_rand = 0;
    rst_prev = 1'b0; rst_next = 1'b1; rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_r[p] = 1'b0; outst[p] = 1'b0; done_seen[p] = 1'b0; gnt_seen[p] = 1'b0;
      fld[p] = '0;
    end
    for (int i = 0; i < 8; i++) rd_v[i] = 1'b0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.mem_rdata = '0;
    model_reset();
    ram[16'h8002]     = 16'h1234;
    ref_mem[16'h8002] = 16'h1234;

    // reset, then check the idle state
    ticks(3);
    rst_next = 1'b0;
    chk_en   = 1'b1;
    ticks(2);

    // single port-0 write
    dq0.push_back(mk(1'b1, 16'h4010, 16'hBEEF));
    ticks(5);

    // single port-1 read of a preloaded word
    dq1.push_back(mk(1'b0, 16'h8002, 16'h0000));
    ticks(8);

    // both ports requesting together for four transactions
    dq0.push_back(mk(1'b1, 16'h1000, 16'hA000));
    dq0.push_back(mk(1'b0, 16'h8002, 16'h0000));
    dq1.push_back(mk(1'b1, 16'h2000, 16'hB000));
    dq1.push_back(mk(1'b0, 16'h1000, 16'h0000));
    ticks(22);

    // port 0 streams, port 1 joins once mid-stream
    for (int i = 0; i < 4; i++) dq0.push_back(mk(1'(i & 1), 16'h3000 + 16'(i), 16'hC000 + 16'(i)));
    ticks(2);
    dq1.push_back(mk(1'b0, 16'h2000, 16'h0000));
    ticks(28);

    // reset pulse while a port-0 read waits on the RAM
    dq0.push_back(mk(1'b0, 16'h8002, 16'h0000));
    ticks(2);
    rst_next = 1'b1;
    tick();
    rst_next = 1'b0;
    ticks(2);
    dq1.push_back(mk(1'b1, 16'hC005, 16'h5A5A));
    ticks(8);

    // randomised traffic with occasional resets and early req drops
    new_pct = 35; keep_pct = 50; drop_pct = 10; rst_rand = 150;
    ticks(1500);
    new_pct = 0; keep_pct = 0; drop_pct = 0; rst_rand = 0;
    ticks(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single 16-bit data-RAM bus (address, write data, write/read strobes, read data) between two requesters: port m0 (CPU load/store path) and port m1 (DMA / UART loader path).
- Sits between the requesters and the chip-select decode / RAM macros. Serialises accesses with a request/grant/done handshake.
- Arbitration is round-robin, so neither port starves. Read data is returned after the RAM's fixed read latency.

Parameters:
- AW, 16, address width of both ports and of the memory bus
- DW, 16, data width
- READ_LAT, 1, cycles from the mem_read strobe cycle to valid mem_rdata; legal range 1..4

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- m0_req  input  1  port 0 request, level; held with fields stable until m0_done
- m0_we  input  1  port 0: 1=write, 0=read
- m0_addr  input  AW  port 0 address
- m0_wdata  input  DW  port 0 write data
- m0_gnt  output  1  one-cycle pulse: port 0 access issued to memory
- m0_done  output  1  one-cycle pulse: port 0 access complete
- m0_rdata  output  DW  port 0 read data, valid while m0_done=1, held until next port 0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as port 0, for port 1
- mem_addr  output  AW  registered address to RAM/decode
- mem_wdata  output  DW  registered write data
- mem_write  output  1  one-cycle write strobe
- mem_read  output  1  one-cycle read strobe
- mem_rdata  input  DW  RAM read data
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (synchronous): all outputs 0, rdata registers 0, state=IDLE, rr_last=1 (port 0 has priority on the first arbitration).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request: stays in IDLE.
- IDLE, request present:
  - winner = the only requester, or on a tie the port != rr_last.
  - Registers winner id, we, addr, wdata; sets rr_last=winner; next state ISSUE.
- ISSUE (1 cycle):
  - mem_addr/mem_wdata driven from captured values.
  - mem_write=we, mem_read=~we; winner gnt=1.
  - Next state: DONE if write; WAIT if read.
- WAIT:
  - Counter runs READ_LAT cycles; ISSUE is counted as cycle 0.
  - At the edge ending cycle ISSUE+READ_LAT, mem_rdata is captured into the winner's rdata register; next state DONE.
  - The other port's rdata is unchanged.
- DONE (1 cycle): winner done=1; next state IDLE.
- Latency, with req first seen in IDLE at cycle 0:
  - write: gnt and strobe at cycle 1, done at cycle 2;
  - read: strobe at cycle 1, done at cycle 2+READ_LAT.
- Requester handshake: must deassert req at the edge ending its done cycle. IDLE samples req the cycle after DONE, so a registered requester never triggers a duplicate access.
- Back-to-back: minimum one IDLE cycle between transactions.
- Requests arriving while busy are held pending and arbitrated in the next IDLE; they are never lost.
- Port requesting continuously while the other also requests: accesses alternate 0,1,0,1.
- mem_addr/mem_wdata hold their last value outside ISSUE; only the strobes mark validity.
- Reset mid-operation (any state): the transaction is abandoned, with no done and no rdata update. Outputs follow the reset rule on the next cycle.
- req dropped by a requester after IDLE captured it: the transaction still completes, since fields are latched.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: m0 always wins when both ports request; rr_last is not used and is not synthesised.
- Undefined: round-robin as described above.
- Handshake and latency are identical in both cases.

Test Plan:
- After reset, m0 write addr=0x4010 wdata=0xBEEF -> cycle1: mem_write=1, mem_addr=0x4010, mem_wdata=0xBEEF, m0_gnt=1; cycle2: m0_done=1; busy 1 on cycles 1-2.
- READ_LAT=1, memory model returns 0x1234 at 0x8002; m1 read 0x8002 -> cycle1: mem_read=1, m1_gnt=1; cycle3: m1_done=1, m1_rdata=0x1234; m0_rdata stays 0.
- Both ports request simultaneously right after reset and re-request on each done for 4 transactions -> grant order 0,1,0,1; each strobe carries the matching port's address.
- m0_req held high with new fields every transaction while m1 requests once -> m1 is granted in the arbitration immediately after m0's current access; no starvation.
- rst pulsed for 1 cycle during WAIT (READ_LAT=3) of an m0 read -> no m0_done, m0_rdata=0, busy=0. A following m1 write to 0xC005 completes with done 2 cycles after IDLE sampling.
- With ARB_FIXED_PRIO_EN defined, both ports requesting for 4 transactions -> m0 granted all 4; m1 granted only once m0_req stays low.
